// File: rtl/bus_arbiter8.sv
// bus_arbiter8: round-robin arbiter that shares one 16-bit valid/ready channel among eight requesters.
// Optional grant locking is compiled in when the BUS_ARB_LOCK_EN macro is defined.
module bus_arbiter8 (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  req,
    input  logic [15:0] data_a,
    input  logic [15:0] data_b,
    input  logic [15:0] data_c,
    input  logic [15:0] data_d,
    input  logic [15:0] data_e,
    input  logic [15:0] data_f,
    input  logic [15:0] data_g,
    input  logic [15:0] data_h,
    input  logic [7:0]  lock,
    output logic        out_valid,
    output logic [15:0] out_data,
    output logic [2:0]  out_src,
    input  logic        out_ready,
    output logic [7:0]  grant,
    output logic [7:0]  ack
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t      state_q;
    logic [2:0]  ptr_q;
    logic [2:0]  src_q;
    logic        valid_q;
    logic [15:0] data_q;
    logic [7:0]  grant_q;

    logic [2:0]  searchBase;
    logic [2:0]  winner;
    logic [2:0]  idx;
    logic        found;
    logic [15:0] wordSel;
    logic        accept;

`ifdef BUS_ARB_LOCK_EN
    logic        lockFlag_q;

    // A locked winner restarts the scan at its own index; if it has let go, the scan moves on to w+1.
    assign searchBase = lockFlag_q ? src_q : ptr_q;
`else
    logic        unusedLock;

    assign unusedLock = ^lock;
    assign searchBase = ptr_q;
`endif

    // First set request bit at or after the search base, wrapping modulo 8.
    always_comb begin
        winner = searchBase;
        idx    = searchBase;
        found  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            idx = searchBase + 3'(k);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        wordSel = data_a;
        case (winner)
            3'd0: wordSel = data_a;
            3'd1: wordSel = data_b;
            3'd2: wordSel = data_c;
            3'd3: wordSel = data_d;
            3'd4: wordSel = data_e;
            3'd5: wordSel = data_f;
            3'd6: wordSel = data_g;
            3'd7: wordSel = data_h;
            default: wordSel = data_a;
        endcase
    end

    assign accept    = valid_q & out_ready;
    assign ack       = {8{accept}} & grant_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_src   = src_q;
    assign grant     = grant_q;

    // Captured word, source and grant stay frozen for the whole BUSY phase.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            ptr_q      <= 3'd0;
            src_q      <= 3'd0;
            valid_q    <= 1'b0;
            data_q     <= 16'h0000;
            grant_q    <= 8'h00;
`ifdef BUS_ARB_LOCK_EN
            lockFlag_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        data_q     <= wordSel;
                        src_q      <= winner;
                        grant_q    <= 8'(1) << winner;
                        valid_q    <= 1'b1;
                        state_q    <= BUSY;
`ifdef BUS_ARB_LOCK_EN
                        lockFlag_q <= 1'b0;
`endif
                    end
                end
                BUSY: begin
                    if (accept) begin
                        valid_q <= 1'b0;
                        grant_q <= 8'h00;
                        state_q <= IDLE;
`ifdef BUS_ARB_LOCK_EN
                        if (lock[src_q]) begin
                            lockFlag_q <= 1'b1;
                        end else begin
                            ptr_q <= src_q + 3'd1;
                        end
`else
                        ptr_q   <= src_q + 3'd1;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
